// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: funct codes,
// FSM state encoding and the funct decoder. Macro: MULDIV_SIGNED_EN.
package muldiv_pkg;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] FIX  = 2'd3;

    // True for the functs that start a multi-cycle operation.
    function automatic logic fn_iter(input logic [5:0] f);
`ifdef MULDIV_SIGNED_EN
        return (f == FN_MULT) || (f == FN_MULTU) ||
               (f == FN_DIV)  || (f == FN_DIVU);
`else
        return (f == FN_MULTU) || (f == FN_DIVU);
`endif
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate.
// Ports: a (value), neg (negate when 1), y (result).
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/alu_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit (shift-add / restoring).
// Ports: clk, rst_n, Start, Funct, Rs, Rt -> Busy, Done, Hi, Lo, DivZero.
// Macro MULDIV_SIGNED_EN enables mult/div and the sign-handling logic.
module alu_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] Rs,
    input  logic [WIDTH-1:0] Rt,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivZero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    // Multiply: {product hi, multiplier/product lo}.
    // Divide:   {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               is_div;
    logic               dz;

    logic               div_fn;
    logic [WIDTH-1:0]   rs_abs;
    logic [WIDTH-1:0]   rt_abs;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   hi_res;
    logic [WIDTH-1:0]   lo_res;

    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     r_sh;
    logic [WIDTH:0]     diff;

    assign div_fn = (Funct == FN_DIV) || (Funct == FN_DIVU);

`ifdef MULDIV_SIGNED_EN
    logic sgn_fn;
    logic rs_neg;
    logic rt_neg;
    logic neg_p;
    logic neg_r;

    assign sgn_fn = (Funct == FN_MULT) || (Funct == FN_DIV);
    assign rs_neg = sgn_fn & Rs[WIDTH-1];
    assign rt_neg = sgn_fn & Rt[WIDTH-1];

    muldiv_negate #(.WIDTH(WIDTH)) u_abs_rs (
        .a   (Rs),
        .neg (rs_neg),
        .y   (rs_abs)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_abs_rt (
        .a   (Rt),
        .neg (rt_neg),
        .y   (rt_abs)
    );

    // neg_p: product/quotient sign; neg_r: remainder follows Rs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_p <= 1'b0;
            neg_r <= 1'b0;
        end else if (Start && state == IDLE && fn_iter(Funct)) begin
            neg_p <= rs_neg ^ rt_neg;
            neg_r <= rs_neg;
        end
    end

    muldiv_negate #(.WIDTH(2*WIDTH)) u_fix_p (
        .a   (acc),
        .neg (neg_p),
        .y   (prod_fix)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_fix_r (
        .a   (acc[2*WIDTH-1:WIDTH]),
        .neg (neg_r),
        .y   (rem_fix)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_fix_q (
        .a   (acc[WIDTH-1:0]),
        .neg (neg_p),
        .y   (quo_fix)
    );
`else
    assign rs_abs   = Rs;
    assign rt_abs   = Rt;
    assign prod_fix = acc;
    assign rem_fix  = acc[2*WIDTH-1:WIDTH];
    assign quo_fix  = acc[WIDTH-1:0];
`endif

    assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + {1'b0, (acc[0] ? opb : '0)};

    assign r_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff = r_sh - {1'b0, opb};

    // A zero divisor leaves the remainder equal to |Rs|, which the
    // remainder sign fix turns back into Rs; only Lo needs forcing.
    assign hi_res = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign lo_res = is_div ? (dz ? '1 : quo_fix)
                           : prod_fix[WIDTH-1:0];

    assign Busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            opb     <= '0;
            is_div  <= 1'b0;
            dz      <= 1'b0;
            Done    <= 1'b0;
            Hi      <= '0;
            Lo      <= '0;
            DivZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start && fn_iter(Funct)) begin
                        cnt     <= '0;
                        DivZero <= 1'b0;
                        is_div  <= div_fn;
                        dz      <= div_fn && (Rt == '0);
                        if (div_fn) begin
                            acc   <= {{WIDTH{1'b0}}, rs_abs};
                            opb   <= rt_abs;
                            state <= DIV;
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, rt_abs};
                            opb   <= rs_abs;
                            state <= MUL;
                        end
                    end else if (Start && Funct == FN_MTHI) begin
                        Hi      <= Rs;
                        Done    <= 1'b1;
                        DivZero <= 1'b0;
                    end else if (Start && Funct == FN_MTLO) begin
                        Lo      <= Rs;
                        Done    <= 1'b1;
                        DivZero <= 1'b0;
                    end
                end
                MUL: begin
                    acc <= {msum, acc[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) state <= FIX;
                end
                DIV: begin
                    if (!diff[WIDTH])
                        acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    else
                        acc <= {r_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    Hi      <= hi_res;
                    Lo      <= lo_res;
                    DivZero <= dz;
                    Done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: arithmetic reference model,
// per-cycle output compare, and hand-computed directed vectors.
`timescale 1ns/1ps
module tb_alu_muldiv;

    localparam int W = 32;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         Start = 1'b0;
    logic [5:0]   Funct = '0;
    logic [W-1:0] Rs    = '0;
    logic [W-1:0] Rt    = '0;
    logic         Busy;
    logic         Done;
    logic         DivZero;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;

    int checks   = 0;
    int failures = 0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Start   (Start),
        .Funct   (Funct),
        .Rs      (Rs),
        .Rt      (Rt),
        .Busy    (Busy),
        .Done    (Done),
        .Hi      (Hi),
        .Lo      (Lo),
        .DivZero (DivZero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit iter_op(input logic [5:0] f);
`ifdef MULDIV_SIGNED_EN
        return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
`else
        return f inside {F_MULTU, F_DIVU};
`endif
    endfunction

    // Architectural result of one HI/LO operation.
    function automatic void golden(input logic [5:0] f,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output logic [W-1:0] hi,
                                   output logic [W-1:0] lo,
                                   output logic dz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        dz = 1'b0;
        if (f == F_MULTU) begin
            p  = {32'b0, a} * {32'b0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (f == F_MULT) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == '0) begin
            hi = a;
            lo = '1;
            dz = 1'b1;
        end else if (f == F_DIVU) begin
            lo = a / b;
            hi = a % b;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endfunction

    // Cycle-level model of the visible behaviour.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_dz   = 1'b0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;
    logic [W-1:0] p_hi   = '0;
    logic [W-1:0] p_lo   = '0;
    logic         p_dz   = 1'b0;
    int           m_left = 0;

    always @(posedge clk or negedge rst_n) begin : model
        logic [W-1:0] h, l;
        logic z;
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_dz   <= p_dz;
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end
            end else if (Start) begin
                if (iter_op(Funct)) begin
                    golden(Funct, Rs, Rt, h, l, z);
                    p_hi   <= h;
                    p_lo   <= l;
                    p_dz   <= z;
                    m_left <= W + 1;
                    m_busy <= 1'b1;
                    m_dz   <= 1'b0;
                end else if (Funct == F_MTHI) begin
                    m_hi   <= Rs;
                    m_done <= 1'b1;
                    m_dz   <= 1'b0;
                end else if (Funct == F_MTLO) begin
                    m_lo   <= Rs;
                    m_done <= 1'b1;
                    m_dz   <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", W'(Busy), W'(m_busy));
        chk("done", W'(Done), W'(m_done));
        chk("divzero", W'(DivZero), W'(m_dz));
        chk("hi", Hi, m_hi);
        chk("lo", Lo, m_lo);
    end

    // Issue one request, then observe a fixed window of cycles.
    task automatic run_op(input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          output int bc, output int dc);
        bc    = 0;
        dc    = 0;
        Funct = f;
        Rs    = a;
        Rt    = b;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        for (int i = 0; i < 38; i++) begin
            bc += int'(Busy);
            dc += int'(Done);
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int bc, dc;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi", Hi, 32'h0);
        chk("rst_lo", Lo, 32'h0);
        chk("rst_busy", W'(Busy), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dc);
        chk("multu_busy_cycles", W'(bc), 32'd33);
        chk("multu_done_pulses", W'(dc), 32'd1);
        chk("multu_hi", Hi, 32'hFFFFFFFE);
        chk("multu_lo", Lo, 32'h00000001);

        run_op(F_MULT, 32'hFFFFFFFC, 32'h4, bc, dc);
`ifdef MULDIV_SIGNED_EN
        chk("mult_busy_cycles", W'(bc), 32'd33);
        chk("mult_hi", Hi, 32'hFFFFFFFF);
        chk("mult_lo", Lo, 32'hFFFFFFF0);
`else
        chk("mult_ignored_busy", W'(bc), 32'd0);
        chk("mult_ignored_done", W'(dc), 32'd0);
        chk("mult_ignored_hi", Hi, 32'hFFFFFFFE);
`endif

        run_op(F_DIV, 32'hFFFFFFF9, 32'h2, bc, dc);
`ifdef MULDIV_SIGNED_EN
        chk("div_lo", Lo, 32'hFFFFFFFD);
        chk("div_hi", Hi, 32'hFFFFFFFF);
        run_op(F_DIV, 32'h7, 32'hFFFFFFFE, bc, dc);
        chk("div_negdiv_lo", Lo, 32'hFFFFFFFD);
        chk("div_negdiv_hi", Hi, 32'h1);
`else
        chk("div_ignored_done", W'(dc), 32'd0);
        chk("div_ignored_lo", Lo, 32'h1);
`endif

        run_op(F_DIVU, 32'd15786, 32'd11068, bc, dc);
        chk("divu_lo", Lo, 32'd1);
        chk("divu_hi", Hi, 32'd4718);
        chk("divu_dz", W'(DivZero), 32'd0);

        run_op(F_DIVU, 32'd5, 32'd0, bc, dc);
        chk("divu0_hi", Hi, 32'd5);
        chk("divu0_lo", Lo, 32'hFFFFFFFF);
        chk("divu0_dz", W'(DivZero), 32'd1);
        chk("divu0_busy_cycles", W'(bc), 32'd33);

        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, bc, dc);
`ifdef MULDIV_SIGNED_EN
        chk("divmin_lo", Lo, 32'h80000000);
        chk("divmin_hi", Hi, 32'h0);
        chk("divmin_dz", W'(DivZero), 32'd0);
        run_op(F_DIV, 32'hFFFFFFFB, 32'h0, bc, dc);
        chk("div0s_hi", Hi, 32'hFFFFFFFB);
        chk("div0s_lo", Lo, 32'hFFFFFFFF);
`else
        chk("divmin_ignored_busy", W'(bc), 32'd0);
        chk("divmin_ignored_done", W'(dc), 32'd0);
        chk("divmin_ignored_hi", Hi, 32'd5);
        chk("divmin_ignored_lo", Lo, 32'hFFFFFFFF);
`endif

        run_op(F_MTHI, 32'h00001234, 32'h0, bc, dc);
        chk("mthi_hi", Hi, 32'h00001234);
        chk("mthi_busy", W'(bc), 32'd0);
        chk("mthi_done", W'(dc), 32'd1);
        chk("mthi_dz", W'(DivZero), 32'd0);

        run_op(F_MTLO, 32'hCAFEF00D, 32'h0, bc, dc);
        chk("mtlo_lo", Lo, 32'hCAFEF00D);
        chk("mtlo_hi", Hi, 32'h00001234);

        run_op(6'b100000, 32'h55, 32'h66, bc, dc);
        chk("bad_fn_done", W'(dc), 32'd0);
        chk("bad_fn_hi", Hi, 32'h00001234);
        chk("bad_fn_lo", Lo, 32'hCAFEF00D);

        Funct = F_MULTU;
        Rs    = 32'h00010000;
        Rt    = 32'h00030005;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (8) @(negedge clk);
        Rs    = 32'd9;
        Rt    = 32'd9;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Done) break;
            @(negedge clk);
        end
        chk("busy_start_done_seen", W'(Done), 32'd1);
        chk("busy_start_hi", Hi, 32'h00000003);
        chk("busy_start_lo", Lo, 32'h00050000);
        @(negedge clk);

        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", W'(Busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_busy", W'(Busy), 32'd0);
        chk("mid_reset_hi", Hi, 32'h0);
        chk("mid_reset_lo", Lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            dc += int'(Done);
        end
        chk("post_reset_no_done", W'(dc), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
